// File: rtl/crop_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crop_pkg
//  Description : Shared types and helpers for the crop controller and the
//                crop datapath: width functions, controller state encoding
//                and the crop-window validity check.
//  Revision    : 1.0  initial release
// ============================================================================
package crop_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    // Row coordinate width; one extra bit so IN_ROWS itself is representable
    function automatic int row_w(input int in_rows);
        return $clog2(in_rows) + 1;
    endfunction

    // Column coordinate width; one extra bit so IN_COLS itself is representable
    function automatic int col_w(input int in_cols);
        return $clog2(in_cols) + 1;
    endfunction

    // A window is legal when non-empty and fully inside the image.
    // Arithmetic is 32-bit so the bound sums cannot overflow.
    function automatic logic cfg_ok(input int y1, input int x1,
                                    input int rows, input int cols,
                                    input int in_rows, input int in_cols);
        return (rows >= 1) && (cols >= 1) &&
               (y1 + rows <= in_rows) && (x1 + cols <= in_cols);
    endfunction

endpackage
`default_nettype wire

// File: rtl/crop_pos_counter.sv
`default_nettype none
// ============================================================================
//  Module      : crop_pos_counter
//  Description : Raster x/y position counter. Advances on en, x wraps at
//                COLS-1 and carries into y, y wraps at ROWS-1. last flags the
//                final pixel of the frame.
//  Revision    : 1.0  initial release
// ============================================================================
module crop_pos_counter #(
    parameter int COLS  = 40,
    parameter int ROWS  = 40,
    parameter int COL_W = 7,
    parameter int ROW_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [COL_W-1:0] x,
    output logic [ROW_W-1:0] y,
    output logic             last
);

    logic x_end;
    logic y_end;

    assign x_end = (x == COL_W'(COLS - 1));
    assign y_end = (y == ROW_W'(ROWS - 1));
    assign last  = x_end & y_end;

    // Raster-order position update with row carry and frame wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x_end) begin
                x <= '0;
                y <= y_end ? '0 : y + ROW_W'(1);
            end else begin
                x <= x + COL_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/crop_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : crop_ctrl
//  Description : Run-time controller for the crop datapath. Validates window
//                configurations into a shadow register, promotes them at
//                frame boundaries, tracks pixel position and sequences
//                start/stop so frames are never cut short.
//  Revision    : 1.0  initial release
// ============================================================================
module crop_ctrl
    import crop_pkg::*;
#(
    parameter  int IN_ROWS  = 40,
    parameter  int IN_COLS  = 40,
    parameter  int DEF_Y1   = 10,
    parameter  int DEF_X1   = 10,
    parameter  int DEF_ROWS = 20,
    parameter  int DEF_COLS = 20,
    parameter  int FCNT_W   = 16,
    localparam int ROW_W    = row_w(IN_ROWS),
    localparam int COL_W    = col_w(IN_COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ROW_W-1:0]  cfg_y1,
    input  logic [COL_W-1:0]  cfg_x1,
    input  logic [ROW_W-1:0]  cfg_rows,
    input  logic [COL_W-1:0]  cfg_cols,
    output logic              cfg_err,
    input  logic              start,
    input  logic              stop,
    input  logic              pix_fire,
    output logic              win_en,
    output logic [COL_W-1:0]  x_pos,
    output logic [ROW_W-1:0]  y_pos,
    output logic              pass,
    output logic [ROW_W-1:0]  win_y_lo,
    output logic [ROW_W-1:0]  win_y_hi,
    output logic [COL_W-1:0]  win_x_lo,
    output logic [COL_W-1:0]  win_x_hi,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              busy
);

    localparam logic [ROW_W-1:0] DEF_Y_LO = ROW_W'(DEF_Y1);
    localparam logic [ROW_W-1:0] DEF_Y_HI = ROW_W'(DEF_Y1 + DEF_ROWS);
    localparam logic [COL_W-1:0] DEF_X_LO = COL_W'(DEF_X1);
    localparam logic [COL_W-1:0] DEF_X_HI = COL_W'(DEF_X1 + DEF_COLS);

    state_t state;
    state_t state_nxt;

    logic             fire;
    logic             last;
    logic             last_fire;
    logic             accept;
    logic             legal;
    logic             promote;
    logic             pending;
    logic [ROW_W-1:0] sh_y_lo;
    logic [ROW_W-1:0] sh_y_hi;
    logic [COL_W-1:0] sh_x_lo;
    logic [COL_W-1:0] sh_x_hi;

    // The datapath is enabled in every non-idle state; pixels only count then
    assign win_en    = (state != IDLE);
    assign busy      = (state != IDLE);
    assign fire      = pix_fire & win_en;
    assign last_fire = fire & last;

    // Shadow holds at most one configuration; accept only when it is free
    assign cfg_ready = ~pending;
    assign accept    = cfg_valid & cfg_ready;
    assign legal     = cfg_ok(int'(cfg_y1), int'(cfg_x1), int'(cfg_rows),
                              int'(cfg_cols), IN_ROWS, IN_COLS);

    // A pending window goes live immediately when idle, otherwise only as
    // the last pixel fires so the next frame starts with it at (0,0)
    assign promote = pending & ((state == IDLE) | last_fire);

    assign pass = (y_pos >= win_y_lo) && (y_pos < win_y_hi) &&
                  (x_pos >= win_x_lo) && (x_pos < win_x_hi);

    crop_pos_counter #(
        .COLS  (IN_COLS),
        .ROWS  (IN_ROWS),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_pos (
        .clk   (clk),
        .reset (reset),
        .en    (fire),
        .x     (x_pos),
        .y     (y_pos),
        .last  (last)
    );

    // Config intake: legal configs fill the shadow, illegal ones flag an error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
            cfg_err <= 1'b0;
            sh_y_lo <= '0;
            sh_y_hi <= '0;
            sh_x_lo <= '0;
            sh_x_hi <= '0;
        end else begin
            cfg_err <= accept & ~legal;
            if (promote) begin
                pending <= 1'b0;
            end else if (accept && legal) begin
                pending <= 1'b1;
                sh_y_lo <= cfg_y1;
                sh_y_hi <= cfg_y1 + cfg_rows;
                sh_x_lo <= cfg_x1;
                sh_x_hi <= cfg_x1 + cfg_cols;
            end
        end
    end

    // Active window bounds, all four updated together on promotion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_y_lo <= DEF_Y_LO;
            win_y_hi <= DEF_Y_HI;
            win_x_lo <= DEF_X_LO;
            win_x_hi <= DEF_X_HI;
        end else if (promote) begin
            win_y_lo <= sh_y_lo;
            win_y_hi <= sh_y_hi;
            win_x_lo <= sh_x_lo;
            win_x_hi <= sh_x_hi;
        end
    end

    // Frame completion pulse and wrapping frame counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= last_fire;
            if (last_fire) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: stop before any pixel of the frame is an immediate halt,
    // otherwise the frame is drained to its last pixel
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    if ((x_pos == '0) && (y_pos == '0) && !fire) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = STOPPING;
                    end
                end
            end
            STOPPING: begin
                if (last_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_crop_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crop_ctrl
//  Description : Self-checking bench for crop_ctrl. A frame-level reference
//                model (linear pixel index, window bounds as integers) is
//                stepped every clock and compared with all DUT outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_crop_ctrl;

    localparam int IN_ROWS = 40;
    localparam int IN_COLS = 40;
    localparam int NPIX    = IN_ROWS * IN_COLS;
    localparam int ROW_W   = 7;
    localparam int COL_W   = 7;
    localparam int FCNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [ROW_W-1:0]  cfg_y1;
    logic [COL_W-1:0]  cfg_x1;
    logic [ROW_W-1:0]  cfg_rows;
    logic [COL_W-1:0]  cfg_cols;
    logic              cfg_err;
    logic              start;
    logic              stop;
    logic              pix_fire;
    logic              win_en;
    logic [COL_W-1:0]  x_pos;
    logic [ROW_W-1:0]  y_pos;
    logic              pass;
    logic [ROW_W-1:0]  win_y_lo;
    logic [ROW_W-1:0]  win_y_hi;
    logic [COL_W-1:0]  win_x_lo;
    logic [COL_W-1:0]  win_x_hi;
    logic              frame_done;
    logic [FCNT_W-1:0] frame_cnt;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;
    int dut_pass    = 0;

    // Reference model state: m_run 0 idle, 1 running, 2 draining
    int m_run, m_pos, m_pend, m_err, m_done, m_fcnt;
    int m_yl, m_yh, m_xl, m_xh;
    int s_yl, s_yh, s_xl, s_xh;

    crop_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_y1     (cfg_y1),
        .cfg_x1     (cfg_x1),
        .cfg_rows   (cfg_rows),
        .cfg_cols   (cfg_cols),
        .cfg_err    (cfg_err),
        .start      (start),
        .stop       (stop),
        .pix_fire   (pix_fire),
        .win_en     (win_en),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .pass       (pass),
        .win_y_lo   (win_y_lo),
        .win_y_hi   (win_y_hi),
        .win_x_lo   (win_x_lo),
        .win_x_hi   (win_x_hi),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_pend = 0; m_err = 0; m_done = 0; m_fcnt = 0;
        m_yl = 10; m_yh = 30; m_xl = 10; m_xh = 30;
        s_yl = 0; s_yh = 0; s_xl = 0; s_xh = 0;
    endtask

    // One clock of the specified behaviour, from the inputs seen at the edge
    task automatic model_step();
        int y1, x1, rows, cols;
        bit fire, last, acc, ok;
        y1 = int'(cfg_y1); x1 = int'(cfg_x1);
        rows = int'(cfg_rows); cols = int'(cfg_cols);
        fire = pix_fire && (m_run != 0);
        last = fire && (m_pos == NPIX - 1);
        acc  = cfg_valid && (m_pend == 0);
        ok   = rows >= 1 && cols >= 1 && y1 + rows <= IN_ROWS && x1 + cols <= IN_COLS;
        m_err  = (acc && !ok) ? 1 : 0;
        m_done = last ? 1 : 0;
        if (last) m_fcnt = (m_fcnt + 1) % (1 << FCNT_W);
        if (m_pend != 0 && (m_run == 0 || last)) begin
            m_yl = s_yl; m_yh = s_yh; m_xl = s_xl; m_xh = s_xh;
            m_pend = 0;
        end else if (acc && ok) begin
            s_yl = y1; s_yh = y1 + rows; s_xl = x1; s_xh = x1 + cols;
            m_pend = 1;
        end
        case (m_run)
            0: if (start && !stop) m_run = 1;
            1: if (stop) m_run = (m_pos == 0 && !fire) ? 0 : 2;
            default: if (last) m_run = 0;
        endcase
        if (fire) m_pos = (m_pos + 1) % NPIX;
    endtask

    task automatic compare_all();
        int ex, ey;
        bit ep;
        ex = m_pos % IN_COLS;
        ey = m_pos / IN_COLS;
        ep = (ey >= m_yl) && (ey < m_yh) && (ex >= m_xl) && (ex < m_xh);
        check("win_en",     32'(win_en),     32'(m_run != 0));
        check("busy",       32'(busy),       32'(m_run != 0));
        check("x_pos",      32'(x_pos),      ex);
        check("y_pos",      32'(y_pos),      ey);
        check("pass",       32'(pass),       32'(ep));
        check("win_y_lo",   32'(win_y_lo),   m_yl);
        check("win_y_hi",   32'(win_y_hi),   m_yh);
        check("win_x_lo",   32'(win_x_lo),   m_xl);
        check("win_x_hi",   32'(win_x_hi),   m_xh);
        check("cfg_ready",  32'(cfg_ready),  32'(m_pend == 0));
        check("cfg_err",    32'(cfg_err),    m_err);
        check("frame_done", 32'(frame_done), m_done);
        check("frame_cnt",  32'(frame_cnt),  m_fcnt);
    endtask

    // Inputs are set at the negedge; the edge is modelled, outputs checked
    // at the following negedge
    task automatic cycle();
        if (pix_fire && win_en && pass) dut_pass++;
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic offer_cfg(input int y1, input int x1, input int rows, input int cols);
        cfg_y1 = ROW_W'(y1); cfg_x1 = COL_W'(x1);
        cfg_rows = ROW_W'(rows); cfg_cols = COL_W'(cols);
    endtask

    initial begin
        int guard, fc_before;
        reset = 1'b0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0; pix_fire = 1'b0;
        offer_cfg(0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        reset = 1'b1;

        // Default window over one full frame
        start = 1'b1;
        cycle();
        check("start_lat", 32'(win_en), 1);
        dut_pass = 0;
        pix_fire = 1'b1;
        repeat (NPIX) cycle();
        check("pass_cnt_def", dut_pass, 400);
        check("fcnt_first", 32'(frame_cnt), 1);

        // Mid-frame config held in shadow until the frame boundary
        dut_pass = 0;
        repeat (700) cycle();
        cfg_valid = 1'b1; offer_cfg(0, 0, 5, 40);
        cycle();
        cfg_valid = 1'b0;
        check("rdy_pending", 32'(cfg_ready), 0);
        check("win_held", 32'(win_y_hi), 30);
        repeat (NPIX - 701) cycle();
        check("pass_cnt_old", dut_pass, 400);
        check("win_yhi_new", 32'(win_y_hi), 5);
        dut_pass = 0;
        repeat (NPIX) cycle();
        check("pass_cnt_new", dut_pass, 200);

        // Illegal config is consumed with an error pulse, then a legal one
        cfg_valid = 1'b1; offer_cfg(30, 0, 11, 5);
        cycle();
        check("err_pulse", 32'(cfg_err), 1);
        cfg_valid = 1'b0;
        cycle();
        check("err_once", 32'(cfg_err), 0);
        check("win_kept", 32'(win_y_hi), 5);
        cfg_valid = 1'b1; offer_cfg(2, 3, 4, 5);
        cycle();
        cfg_valid = 1'b0;
        check("rdy_after_err", 32'(cfg_ready), 0);

        // Stop at pixel 100 drains the whole frame
        guard = 0;
        while (m_pos != 100 && guard < 4 * NPIX) begin cycle(); guard++; end
        check("align_100", m_pos, 100);
        fc_before = m_fcnt;
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check("stopping_busy", 32'(busy), 1);
        repeat (NPIX - 102) cycle();
        check("still_busy", 32'(busy), 1);
        cycle();
        check("idle_after", 32'(win_en), 0);
        check("fcnt_stop", 32'(frame_cnt), fc_before + 1);
        start = 1'b0;
        repeat (3) cycle();

        // Asynchronous reset mid-frame
        start = 1'b1;
        guard = 0;
        while (m_pos != 800 && guard < 2 * NPIX) begin cycle(); guard++; end
        check("align_800", m_pos, 800);
        reset = 1'b0; start = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_fcnt", 32'(frame_cnt), 0);
        cycle();
        reset = 1'b1;
        cycle();

        // start+stop together stay idle; stop at (0,0) halts at once
        pix_fire = 1'b0; start = 1'b1; stop = 1'b1;
        repeat (3) cycle();
        check("both_idle", 32'(win_en), 0);
        stop = 1'b0;
        cycle();
        start = 1'b0; stop = 1'b1;
        cycle();
        check("stop_at_origin", 32'(busy), 0);
        check("no_done", 32'(frame_done), 0);
        stop = 1'b0;

        // Randomised traffic
        repeat (12000) begin
            pix_fire  = ($urandom % 4) != 0;
            start     = ($urandom % 16) != 0;
            stop      = ($urandom % 1200) == 0;
            cfg_valid = ($urandom % 8) == 0;
            if ($urandom % 2) begin
                int y1, x1;
                y1 = $urandom_range(0, IN_ROWS - 1);
                x1 = $urandom_range(0, IN_COLS - 1);
                offer_cfg(y1, x1, $urandom_range(1, IN_ROWS - y1),
                          $urandom_range(1, IN_COLS - x1));
            end else begin
                offer_cfg($urandom_range(0, IN_ROWS), $urandom_range(0, IN_COLS),
                          $urandom_range(0, IN_ROWS), $urandom_range(0, IN_COLS));
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/crop_ctrl.md
Name: crop_ctrl

Overview:
- Run-time controller for the crop datapath.
- Accepts crop-window configurations over a valid/ready port, validates them and holds them in a shadow register.
- Promotes the shadow to the active window only at frame boundaries.
- Tracks the pixel position by observing the datapath's pixel handshake, and drives the active window bounds, the position, the pass decision and the datapath enable.
- Sequences start/stop so the window never changes mid-frame and a stop never truncates a frame.

Parameters:
- IN_ROWS, 40, input image height in pixels
- IN_COLS, 40, input image width in pixels
- DEF_Y1, 10, reset value of the active window top row
- DEF_X1, 10, reset value of the active window left column
- DEF_ROWS, 20, reset value of the active window height
- DEF_COLS, 20, reset value of the active window width
- FCNT_W, 16, width of the frame counter

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  controller can accept a configuration
- cfg_y1  in  ROW_W  requested top row
- cfg_x1  in  COL_W  requested left column
- cfg_rows  in  ROW_W  requested height
- cfg_cols  in  COL_W  requested width
- cfg_err  out  1  one-cycle pulse: the last accepted configuration was rejected
- start  in  1  level request to begin streaming
- stop  in  1  level request to stop after the current frame
- pix_fire  in  1  datapath pixel handshake (in_valid & in_ready)
- win_en  out  1  datapath enable; the datapath gates its in_ready with this
- x_pos  out  COL_W  column of the next pixel
- y_pos  out  ROW_W  row of the next pixel
- pass  out  1  next pixel lies inside the active window
- win_y_lo, win_y_hi  out  ROW_W  active rows [lo, hi)
- win_x_lo, win_x_hi  out  COL_W  active columns [lo, hi)
- frame_done  out  1  one-cycle pulse after the last pixel of a frame fires
- frame_cnt  out  FCNT_W  completed frames; wraps modulo 2^FCNT_W
- busy  out  1  state != IDLE

Behaviour:
- Widths: ROW_W = $clog2(IN_ROWS)+1, COL_W = $clog2(IN_COLS)+1. Bound sums are computed one bit wider, so they cannot overflow.
- Reset values (reset low):
  - state = IDLE; x_pos = y_pos = 0.
  - Active window = DEF_* values; shadow pending = 0.
  - cfg_ready = 1; cfg_err = 0, frame_done = 0, frame_cnt = 0, win_en = 0.
- Reset asserted mid-frame abandons the frame. There is no partial frame_done.
- Config handshake:
  - A configuration is accepted on cfg_valid & cfg_ready.
  - cfg_ready = !pending.
  - Validity: rows ≥ 1, cols ≥ 1, y1 + rows ≤ IN_ROWS, x1 + cols ≤ IN_COLS.
  - Invalid: the configuration is consumed but discarded, and cfg_err pulses on the next cycle.
  - Valid: it is stored in the shadow and pending is set.
- Promotion of the shadow to the active window:
  - In IDLE: on the cycle after pending is set.
  - In RUN or STOPPING: only on the cycle in which the last pixel of a frame fires (x = IN_COLS-1, y = IN_ROWS-1). The new window takes effect from pixel (0,0) of the next frame.
  - Promotion clears pending.
  - A configuration accepted on a boundary cycle is not promoted on that boundary; it waits for the next one.
- States:
  - IDLE: win_en = 0 and pix_fire is ignored. start = 1 and stop = 0 moves to RUN next cycle. start and stop high together keep IDLE.
  - RUN: win_en = 1. stop = 1 moves to STOPPING. If x_pos = y_pos = 0 (no pixel of the current frame has fired yet, pix_fire = 0 this cycle), the move goes directly to IDLE instead.
  - STOPPING: win_en = 1. On the last-pixel fire, move to IDLE. Deasserting stop does not cancel STOPPING.
- Position counting:
  - Counters advance only on pix_fire & win_en.
  - x wraps IN_COLS-1 → 0; y increments on the x wrap and wraps IN_ROWS-1 → 0.
  - In IDLE the counters hold at 0.
- Frame completion: on the last-pixel fire, frame_done pulses on the next cycle and frame_cnt increments (wraps).
- pass: combinational from the registered position and the active window, (y_pos in [win_y_lo, win_y_hi)) & (x_pos in [win_x_lo, win_x_hi)).
- Window outputs: registered, updated together on promotion. hi = lo + size.
- Latency:
  - start to win_en: 1 cycle.
  - Last-pixel fire to window change, frame_done and IDLE: 1 cycle.

Decomposition:
- Shared package crop_pkg:
  - ROW_W and COL_W width functions.
  - The state encoding (IDLE = 2'd0, RUN = 2'd1, STOPPING = 2'd2).
  - A cfg-validity function.
- Sub-module crop_pos_counter: x/y counter with enable, wrap and last-pixel flag. It is reusable by the datapath.

Test Plan:
- Reset, then start=1 and 1600 consecutive pix_fire → win_en rises 1 cycle after start; pass is high for exactly 400 pixels (rows 10-29, cols 10-29); one frame_done pulse; frame_cnt = 1.
- cfg y1=0, x1=0, rows=5, cols=40, offered at pixel 700 of a RUN frame → accepted with cfg_ready then 0; the window is unchanged until the last pixel; the next frame passes exactly 200 pixels; win_y_hi = 5.
- cfg y1=30, rows=11 → accepted and cfg_err pulses once; window unchanged; a following valid config is accepted.
- stop at pixel 100 of a frame → state STOPPING; IDLE only after pixel 1599; win_en low afterwards; frame_cnt incremented once.
- Reset pulled low at pixel 800 → all outputs at reset values asynchronously; after release, frame_cnt = 0 and position = (0,0).
- start and stop both high in IDLE → stays IDLE with win_en = 0; stop while RUN at (0,0) → IDLE next cycle, no frame_done.
